alu_pipe_fifo: RTL and testbench
================================

# alu_pipe_fifo

Parametrised, pipelined successor to the 8-bit ALU DUT: accepts operand/opcode transactions under a valid/ready handshake, computes a double-width result in one registered stage, and buffers results in an in-order output FIFO with consumer backpressure. It sits between the stimulus side (driver) and the result consumer (monitor/scoreboard or downstream logic). Unlike the previous generation, it never drops results when the consumer stalls.

## Interface

- WIDTH, 8: operand width in bits (≥ 2).
- DEPTH, 4: output FIFO entries (power of 2, ≥ 2).
- clk  input  1  clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- vld  input  1  input transaction valid.
- rdy  output  1  block can accept; a transfer occurs on a rising edge with vld && rdy.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- opcode  input  3  operation select.
- out  output  2*WIDTH  result at FIFO head.
- opVld  output  1  out is valid.
- opRdy  input  1  consumer ready; a pop occurs on a rising edge with opVld && opRdy.
- count  output  $clog2(DEPTH)+1  number of results currently in the FIFO.

## Operation

- Opcodes; all results are 2*WIDTH bits, upper bits zero unless stated otherwise.
  - 0 ADD: a + b; the carry is in bit WIDTH.
  - 1 SUB: a − b, modulo 2^(2*WIDTH), so a negative result is sign-filled.
  - 2 MUL: a × b, unsigned, full width.
  - 3 AND, 4 OR, 5 XOR: bitwise, zero-extended.
  - 6 SHL: zero-extended a shifted left by b mod 2*WIDTH.
  - 7 CMP: bit0 = (a<b), bit1 = (a==b), bit2 = (a>b); all other bits 0.
- Stage S1 is a result register plus a valid bit, loaded from the combinational ALU on accept.
- S1 drains into the FIFO on the next edge, unconditionally. Space for it is guaranteed by the credit rule below.
- rdy = (count + S1 valid) < DEPTH.
  - rdy is computed from registers only.
  - There is no combinational path from opRdy or vld to rdy.
- FIFO:
  - First-word fall-through: out/opVld reflect the head entry.
  - Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is a separate register.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance.
- out holds its value and opVld stays high while opVld && !opRdy.
- Ordering: results leave strictly in acceptance order.
- vld && !rdy: the transaction is ignored. The source must hold it until it is accepted.
- Reset (asynchronous, on reset=0):
  - S1 valid, FIFO pointers and count clear immediately.
  - opVld=0, out=0, count=0, rdy=0 while reset is low.
  - Results in flight are discarded; no stale entry appears after release.
  - rdy=1 on the first rising edge after reset goes high.

## Timing

- Latency: an accept at edge N loads S1 at edge N. The FIFO write is at edge N+1, and out/opVld are valid after edge N+1 when the FIFO was empty.
- Throughput: 1 result per cycle sustained while opRdy=1.
- With opRdy held 0, exactly DEPTH transactions are accepted: DEPTH−1 in the FIFO and 1 in S1, then DEPTH in the FIFO. rdy falls after the accept that makes count + S1 valid = DEPTH.
- After a pop from full, rdy rises on the following edge (one-cycle bubble, by design).
- count updates on the same edge as the push or pop.

## Test plan

Unless a scenario says otherwise: WIDTH=8, DEPTH=4, opRdy=1.

- Arithmetic:
  - ADD a=0xFF, b=0x01 → out=0x0100 with opVld two edges after the accept.
  - SUB 0x01−0x02 → 0xFFFF.
  - MUL 0xFF×0xFF → 0xFE01.
- Logic and compare:
  - XOR 0xA5^0x0F → 0x00AA.
  - SHL a=0x81, b=9 → 0x0200.
  - CMP 0x10 vs 0x20 → 0x0001.
  - CMP 0x20 vs 0x20 → 0x0002.
- Backpressure fill: opRdy=0; drive vld with 6 distinct ADDs back-to-back.
  - Exactly 4 are accepted, rdy=0 thereafter, and count reaches 4.
  - out holds the first result, stable.
  - Raise opRdy: 4 results leave in order, then the remaining 2 are accepted.
- Streaming: 20 back-to-back MULs with opRdy=1.
  - One opVld pulse per cycle after 2-cycle fill.
  - count ≤ 1 and rdy stays 1.
  - Results match the model in order.
- Simultaneous push/pop at count=3 with S1 valid: count stays 3 across the edge and ordering is preserved. Pointer wrap is exercised with more than 8 transactions.
- Reset mid-operation: with count=3 and S1 valid, pull reset low between edges.
  - opVld=0, out=0, count=0, rdy=0 immediately.
  - After release, no result appears until a new accept, and rdy=1 after the first edge.

Source files
------------

// File: rtl/alu_pipe_fifo.sv
// alu_pipe_fifo: valid/ready ALU with one registered result stage (S1)
// feeding an in-order first-word-fall-through result FIFO.
// rdy is derived from registers only. Space for the S1 result is reserved
// when the transaction is accepted, so S1 can always drain into the FIFO
// on the following edge without checking for room.
module alu_pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vld,
  output logic                       rdy,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [2:0]                 opcode,
  output logic [2*WIDTH-1:0]         out,
  output logic                       opVld,
  input  logic                       opRdy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int RW = 2 * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  localparam logic [RW-1:0] SHIFT_MOD = RW'(RW);
  localparam logic [CW:0]   OCC_LIMIT = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);

  // Operand extension and ALU result
  logic [RW-1:0] w_a_ext;
  logic [RW-1:0] w_b_ext;
  logic [RW-1:0] w_shamt;
  logic [RW-1:0] w_res;

  // Handshake and FIFO control
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_occ;
  logic [CW-1:0] w_count_nxt;

  // State
  logic          r_live;
  logic          r_s1_vld;
  logic [RW-1:0] r_s1_res;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [RW-1:0] r_mem [DEPTH];

  assign w_a_ext = {{WIDTH{1'b0}}, a};
  assign w_b_ext = {{WIDTH{1'b0}}, b};
  assign w_shamt = w_b_ext % SHIFT_MOD;

  // Combinational ALU producing the double-width result for the S1 load
  always_comb begin
    w_res = {RW{1'b0}};
    case (opcode)
      OP_ADD:  w_res = w_a_ext + w_b_ext;
      OP_SUB:  w_res = w_a_ext - w_b_ext;
      OP_MUL:  w_res = w_a_ext * w_b_ext;
      OP_AND:  w_res = w_a_ext & w_b_ext;
      OP_OR:   w_res = w_a_ext | w_b_ext;
      OP_XOR:  w_res = w_a_ext ^ w_b_ext;
      OP_SHL:  w_res = w_a_ext << w_shamt;
      OP_CMP:  w_res = {{(RW-3){1'b0}}, (a > b), (a == b), (a < b)};
      default: w_res = {RW{1'b0}};
    endcase
  end

  // Occupancy counts the result held in S1 as well, so an accept always
  // has a FIFO slot reserved. r_live keeps rdy low during and right after reset.
  assign w_occ    = {1'b0, r_count} + {{CW{1'b0}}, r_s1_vld};
  assign rdy      = r_live && (w_occ < OCC_LIMIT);
  assign w_accept = vld && rdy;
  assign w_push   = r_s1_vld;
  assign opVld    = (r_count != {CW{1'b0}});
  assign w_pop    = opVld && opRdy;
  assign count    = r_count;
  assign out      = opVld ? r_mem[r_rptr] : {RW{1'b0}};

  // Next FIFO count from the push/pop pair; push+pop leaves it unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // S1 result stage and the post-reset enable for rdy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live   <= 1'b0;
      r_s1_vld <= 1'b0;
      r_s1_res <= {RW{1'b0}};
    end else begin
      r_live   <= 1'b1;
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_res <= w_res;
      end
    end
  end

  // FIFO pointers and count; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are never visible unless count is non-zero
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= r_s1_res;
    end
  end

endmodule

// File: tb/tb_alu_pipe_fifo.sv
// Directed testbench for alu_pipe_fifo (WIDTH=8, DEPTH=4).
module tb_alu_pipe_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        vld;
  logic        rdy;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  opcode;
  logic [15:0] out;
  logic        opVld;
  logic        opRdy;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  t_op  [0:31];
  logic [7:0]  t_a   [0:31];
  logic [7:0]  t_b   [0:31];
  logic [15:0] t_exp [0:31];

  alu_pipe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .vld    (vld),
    .rdy    (rdy),
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .out    (out),
    .opVld  (opVld),
    .opRdy  (opRdy),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_txn(input int i, input logic [2:0] op, input logic [7:0] xa,
                         input logic [7:0] xb, input logic [15:0] exp);
    t_op[i] = op; t_a[i] = xa; t_b[i] = xb; t_exp[i] = exp;
  endtask

  // One isolated transaction: result visible two edges after the accept, popped on the next.
  task automatic single(input string tag, input logic [2:0] op, input logic [7:0] xa,
                        input logic [7:0] xb, input logic [15:0] exp);
    opRdy = 1'b1; vld = 1'b1; opcode = op; a = xa; b = xb;
    check({tag, "_rdy"}, rdy, 32'd1);
    step();
    vld = 1'b0;
    check({tag, "_s1"}, opVld, 32'd0);
    step();
    check({tag, "_vld"}, opVld, 32'd1);
    check({tag, "_out"}, out, exp);
    step();
    check({tag, "_pop"}, opVld, 32'd0);
  endtask

  // Drive n table entries back-to-back; opRdy=0 for the first 'hold' cycles.
  // mode: 0 plain, 1 streaming, 2 backpressure fill, 3 push/pop at count=3.
  task automatic run(input string tag, input int n, input int mode, input int hold);
    int sent;
    int popped;
    int k;
    bit acc;
    bit pop;
    sent = 0; popped = 0; k = 0;
    while (popped < n && k < 200) begin
      opRdy = (k >= hold);
      vld   = (sent < n);
      if (sent < n) begin
        opcode = t_op[sent]; a = t_a[sent]; b = t_b[sent];
      end
      if (mode == 1) begin
        check({tag, "_cnt_le1"}, (count <= 3'd1), 32'd1);
        check({tag, "_rdy"}, rdy, 32'd1);
      end
      if (mode == 2 && k >= 4 && k < hold) begin
        check({tag, "_rdy_low"}, rdy, 32'd0);
        check({tag, "_head_vld"}, opVld, 32'd1);
        check({tag, "_head_hold"}, out, t_exp[0]);
      end
      if (mode == 2 && k == hold) begin
        check({tag, "_accepted"}, sent, 32'd4);
        check({tag, "_full"}, count, 32'd4);
      end
      if (mode == 3 && k == hold) begin
        check({tag, "_cnt3"}, count, 32'd3);
        check({tag, "_rdy_low"}, rdy, 32'd0);
      end
      if (mode == 3 && k == hold + 1) begin
        check({tag, "_cnt_same"}, count, 32'd3);
      end
      acc = vld && rdy;
      pop = opVld && opRdy;
      if (pop) begin
        check({tag, "_order"}, out, t_exp[popped]);
        popped++;
      end
      step();
      if (acc) sent++;
      k++;
    end
    vld = 1'b0;
    opRdy = 1'b1;
    check({tag, "_done"}, popped, n);
    if (mode == 1) begin
      check({tag, "_cycles"}, k, n + 2);
    end
  endtask

  initial begin
    reset = 1'b0; vld = 1'b0; opRdy = 1'b1; opcode = 3'd0; a = 8'd0; b = 8'd0;

    // Reset state
    step();
    check("rst_opvld", opVld, 32'd0);
    check("rst_out", out, 32'd0);
    check("rst_count", count, 32'd0);
    check("rst_rdy", rdy, 32'd0);
    reset = 1'b1;
    step();
    check("rel_rdy", rdy, 32'd1);
    check("rel_opvld", opVld, 32'd0);

    // Arithmetic, logic and compare
    single("add", 3'd0, 8'hFF, 8'h01, 16'h0100);
    single("sub", 3'd1, 8'h01, 8'h02, 16'hFFFF);
    single("mul", 3'd2, 8'hFF, 8'hFF, 16'hFE01);
    single("xor", 3'd5, 8'hA5, 8'h0F, 16'h00AA);
    single("shl", 3'd6, 8'h81, 8'd9,  16'h0200);
    single("cmp_lt", 3'd7, 8'h10, 8'h20, 16'h0001);
    single("cmp_eq", 3'd7, 8'h20, 8'h20, 16'h0002);
    single("cmp_gt", 3'd7, 8'h30, 8'h20, 16'h0004);
    single("and", 3'd3, 8'hF0, 8'h3C, 16'h0030);
    single("or",  3'd4, 8'hF0, 8'h0F, 16'h00FF);
    single("shl_mod", 3'd6, 8'h01, 8'd17, 16'h0002);

    // Backpressure fill: 6 distinct ADDs, a=1..6, b=0x10
    for (int i = 0; i < 6; i++) begin
      set_txn(i, 3'd0, 8'(i + 1), 8'h10, 16'(16'h0011 + i));
    end
    run("bp", 6, 2, 10);

    // Streaming MULs
    for (int i = 0; i < 20; i++) begin
      logic [7:0] xa;
      logic [7:0] xb;
      xa = 8'(i * 13 + 7);
      xb = 8'(255 - i * 11);
      set_txn(i, 3'd2, xa, xb, {8'd0, xa} * {8'd0, xb});
    end
    run("stream", 20, 1, 0);

    // Push/pop at count=3 with S1 valid, mixed ops, pointers wrap
    set_txn(0, 3'd0, 8'h80, 8'h80, 16'h0100);
    set_txn(1, 3'd1, 8'h05, 8'h03, 16'h0002);
    set_txn(2, 3'd3, 8'hF0, 8'h3C, 16'h0030);
    set_txn(3, 3'd4, 8'hF0, 8'h0F, 16'h00FF);
    set_txn(4, 3'd6, 8'h01, 8'd17, 16'h0002);
    set_txn(5, 3'd7, 8'h30, 8'h20, 16'h0004);
    set_txn(6, 3'd5, 8'hFF, 8'h01, 16'h00FE);
    set_txn(7, 3'd2, 8'h10, 8'h10, 16'h0100);
    set_txn(8, 3'd0, 8'hFF, 8'hFF, 16'h01FE);
    set_txn(9, 3'd1, 8'h00, 8'h01, 16'hFFFF);
    run("pp", 10, 3, 4);

    // Reset mid-operation with count=3 and S1 valid
    opRdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1; opcode = 3'd0; a = 8'(i); b = 8'h01;
      step();
    end
    vld = 1'b0;
    check("mid_cnt3", count, 32'd3);
    check("mid_opvld", opVld, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_opvld", opVld, 32'd0);
    check("mid_rst_out", out, 32'd0);
    check("mid_rst_count", count, 32'd0);
    check("mid_rst_rdy", rdy, 32'd0);
    step();
    reset = 1'b1;
    opRdy = 1'b1;
    step();
    check("post_rst_rdy", rdy, 32'd1);
    check("post_rst_opvld", opVld, 32'd0);
    check("post_rst_count", count, 32'd0);
    step();
    check("post_rst_idle", opVld, 32'd0);
    single("post_rst", 3'd0, 8'h03, 8'h04, 16'h0007);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
